sequence_det: RTL and testbench
===============================

SEQUENCE_DET -- requirements
Module: sequence_det

Interface
REQ-001 Port order SHALL be x, clk, reset, z, so that positional instantiation works.
REQ-002 clk  input  1  single clock; all state updates occur on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; 0 = asserted, 1 = run.
REQ-004 x  input  1  serial data bit, sampled on each rising clk edge.
REQ-005 z  output  1  detect flag; 1 for exactly one clock cycle per detected pattern.
REQ-006 The module SHALL have no parameters; the pattern is fixed at 0110, first-received bit first.

Function
REQ-007 The block SHALL be a Moore FSM; z SHALL depend only on the current state, never combinationally on x.
REQ-008 The FSM SHALL have exactly five states: S_IDLE, S_0, S_01, S_011 and S_HIT.
REQ-009 S_IDLE transitions: x=0 -> S_0; x=1 -> S_IDLE.
REQ-010 S_0 transitions: x=0 -> S_0; x=1 -> S_01.
REQ-011 S_01 transitions: x=0 -> S_0; x=1 -> S_011.
REQ-012 S_011 transitions: x=0 -> S_HIT; x=1 -> S_IDLE.
REQ-013 S_HIT transitions: x=0 -> S_0; x=1 -> S_01, so that overlapping patterns are detected (the trailing 0 starts the next match).
REQ-014 z SHALL be 1 only in S_HIT and 0 in all other states.
REQ-015 Latency: z SHALL rise in the cycle immediately after the edge that samples the final 0 of 0110, and fall one cycle later unless a further hit follows.
REQ-016 An X on x SHALL never be treated as a hit; any unreachable encoding SHALL return to S_IDLE on the next edge with z=0.

Reset
REQ-017 While reset=0, the state SHALL be S_IDLE and z SHALL be 0 immediately, without waiting for a clock edge.
REQ-018 Deassertion (reset 0->1) SHALL be treated as synchronous to clk by the integrator; the first sample is taken on the first rising edge with reset=1.
REQ-019 Asserting reset mid-pattern SHALL discard all partial-match history.

Structure
REQ-020 State encodings (3-bit binary: S_IDLE=0, S_0=1, S_01=2, S_011=3, S_HIT=4) SHALL be defined as constants in a shared package, seq_det_pkg.
REQ-021 The design SHALL be a single module with a state register, next-state logic and output decode; no sub-module is used.

Verification
REQ-022 Hold reset=0 for 2 cycles with any x -> z=0 throughout and state S_IDLE; z stays 0 on the first edge after release with x=1.
REQ-023 After reset, drive x=0,1,1,0 on 4 consecutive edges -> z=1 for exactly the one cycle following the 4th edge.
REQ-024 Drive x=0,1,1,0,1,1,0 -> z pulses twice, 3 cycles apart (overlap check).
REQ-025 Drive the pattern 0011 four times (16 bits) -> exactly 3 single-cycle z pulses, 4 cycles apart, the first one cycle after the 5th sampled bit.
REQ-026 Drive x=0,1,1,1,0 and then x=1,1,1,1 -> z stays 0 throughout.
REQ-027 Drive x=0,1,1, assert reset asynchronously between edges, release it, then drive x=0 -> z stays 0; z must drop to 0 immediately if reset is asserted while in S_HIT.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared definitions for the 0110 serial pattern detector.
// Binary state encodings are fixed so that waveforms and downstream decoders agree.
package seq_det_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_0    = 3'd1,
    S_01   = 3'd2,
    S_011  = 3'd3,
    S_HIT  = 3'd4
  } state_t;

endpackage

// File: rtl/sequence_det.sv
// Moore FSM that detects the serial pattern 0110 (first bit first), overlaps allowed.
// z is a pure decode of the current state and pulses for one cycle per match.
module sequence_det
  import seq_det_pkg::*;
(
  input  logic x,
  input  logic clk,
  input  logic reset,
  output logic z
);

  state_t r_state;
  state_t w_next;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // An X on x falls into the inner defaults and abandons the partial match.
  always_comb begin
    // NOTE: default assigned first so no path leaves w_next unassigned (no latch).
    w_next = S_IDLE;
    case (r_state)
      S_IDLE: begin
        case (x)
          1'b0:    w_next = S_0;
          1'b1:    w_next = S_IDLE;
          default: w_next = S_IDLE;
        endcase
      end
      S_0: begin
        case (x)
          1'b0:    w_next = S_0;
          1'b1:    w_next = S_01;
          default: w_next = S_IDLE;
        endcase
      end
      S_01: begin
        case (x)
          1'b0:    w_next = S_0;
          1'b1:    w_next = S_011;
          default: w_next = S_IDLE;
        endcase
      end
      S_011: begin
        case (x)
          1'b0:    w_next = S_HIT;
          1'b1:    w_next = S_IDLE;
          default: w_next = S_IDLE;
        endcase
      end
      S_HIT: begin
        // Trailing 0 of a hit is the leading 0 of the next candidate.
        case (x)
          1'b0:    w_next = S_0;
          1'b1:    w_next = S_01;
          default: w_next = S_IDLE;
        endcase
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign z = (r_state == S_HIT);

endmodule

// File: tb/tb_sequence_det.sv
// Self-checking bench for sequence_det: directed scenarios plus randomized traffic
// compared against a "last four bits since reset" reference model.
module tb_sequence_det;
  import seq_det_pkg::*;

  logic x;
  logic clk;
  logic reset;
  logic z;

  int total = 0;
  int bad   = 0;

  // Reference model: bits seen since the last reset, newest in bit 0.
  logic [3:0] m_hist;
  int         m_cnt;
  logic       m_z;

  sequence_det dut (
    .x     (x),
    .clk   (clk),
    .reset (reset),
    .z     (z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    m_hist = 4'b0000;
    m_cnt  = 0;
    m_z    = 1'b0;
  endtask

  // Drive one bit, let the rising edge sample it, then update the model 1 ns later.
  task automatic drive_bit(input logic b);
    x = b;
    @(posedge clk);
    #1;
    if (reset) begin
      m_hist = {m_hist[2:0], b};
      if (m_cnt < 4) m_cnt++;
    end
    m_z = (m_cnt == 4) && (m_hist == 4'b0110);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    x     = 1'b0;
    model_clear();
    #2;
    total++;
    if (z !== 1'b0) begin
      bad++;
      $display("FAIL reset_initial: z=%b expected 0", z);
    end
    for (int i = 0; i < 2; i++) begin
      x = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      total++;
      if (z !== 1'b0 || dut.r_state !== S_IDLE) begin
        bad++;
        $display("FAIL reset_hold[%0d]: z=%b state=%0d expected z=0 state=0", i, z, dut.r_state);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    drive_bit(1'b1);
    total++;
    if (z !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: z=%b expected 0", z);
    end
  endtask

  task automatic test_single();
    logic [3:0] bits = 4'b0110;
    logic [3:0] zexp = 4'b0001;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_bit(bits[3-i]);
      total++;
      if (z !== zexp[3-i]) begin
        bad++;
        $display("FAIL single[%0d]: z=%b expected %b", i, z, zexp[3-i]);
      end
    end
    drive_bit(1'b1);
    total++;
    if (z !== 1'b0) begin
      bad++;
      $display("FAIL single_fall: z=%b expected 0", z);
    end
  endtask

  task automatic test_overlap();
    logic [6:0] bits = 7'b0110110;
    logic [6:0] zexp = 7'b0001001;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive_bit(bits[6-i]);
      total++;
      if (z !== zexp[6-i]) begin
        bad++;
        $display("FAIL overlap[%0d]: z=%b expected %b", i, z, zexp[6-i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] bits = 16'b0011_0011_0011_0011;
    logic [15:0] zexp = 16'b0000_1000_1000_1000;
    int pulses = 0;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive_bit(bits[15-i]);
      if (z === 1'b1) pulses++;
      total++;
      if (z !== zexp[15-i]) begin
        bad++;
        $display("FAIL back_to_back[%0d]: z=%b expected %b", i, z, zexp[15-i]);
      end
    end
    total++;
    if (pulses != 3) begin
      bad++;
      $display("FAIL back_to_back_count: pulses=%0d expected 3", pulses);
    end
  endtask

  task automatic test_no_hit();
    logic [8:0] bits = 9'b01110_1111;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive_bit(bits[8-i]);
      total++;
      if (z !== 1'b0) begin
        bad++;
        $display("FAIL no_hit[%0d]: z=%b expected 0", i, z);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    #2;
    reset = 1'b0;
    model_clear();
    #1;
    total++;
    if (z !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_assert: z=%b expected 0", z);
    end
    @(negedge clk);
    reset = 1'b1;
    drive_bit(1'b0);
    total++;
    if (z !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_history: z=%b expected 0", z);
    end
    // Reach S_HIT, then assert reset between edges: z must drop at once.
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b0);
    total++;
    if (z !== 1'b1) begin
      bad++;
      $display("FAIL reset_hit_reach: z=%b expected 1", z);
    end
    #2;
    reset = 1'b0;
    model_clear();
    #1;
    total++;
    if (z !== 1'b0) begin
      bad++;
      $display("FAIL reset_hit_drop: z=%b expected 0", z);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_random();
    int hits = 0;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 79) == 0) begin
        #2;
        reset = 1'b0;
        model_clear();
        #1;
        total++;
        if (z !== 1'b0) begin
          bad++;
          $display("FAIL random_reset[%0d]: z=%b expected 0", i, z);
        end
        @(negedge clk);
        reset = 1'b1;
      end
      // Bias toward 0110 fragments so hits and near-misses are frequent.
      if ($urandom_range(0, 3) == 0) begin
        drive_bit(1'b0);
        total++;
        if (z !== m_z) begin
          bad++;
          $display("FAIL random[%0d]: z=%b expected %b", i, z, m_z);
        end
        drive_bit(1'b1);
        total++;
        if (z !== m_z) begin
          bad++;
          $display("FAIL random[%0d]: z=%b expected %b", i, z, m_z);
        end
      end
      drive_bit(1'($urandom_range(0, 1)));
      if (m_z) hits++;
      total++;
      if (z !== m_z) begin
        bad++;
        $display("FAIL random[%0d]: z=%b expected %b", i, z, m_z);
      end
    end
    $display("random phase: %0d model hits", hits);
  endtask

  initial begin
    test_reset();
    test_single();
    test_overlap();
    test_back_to_back();
    test_no_hit();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
